imm_branch_gen: RTL and testbench

//  Parametrised immediate-extension and branch-target unit for the single-cycle CPU datapath.

---
 rtl/imm_branch_gen_if.sv | 31 +++
 rtl/imm_branch_gen.sv | 163 ++++++++++++++++
 tb/tb_imm_branch_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_branch_gen_if.sv
// Decode-to-PC-select bus for imm_branch_gen: input handshake, operands, flush and
// the buffered result.
interface imm_branch_gen_if #(
    parameter int DATA_W = 24,
    parameter int IMM_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] pc;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] target;
    logic              jump_up;
    logic              jump_down;
    logic              jump_none;
    logic              wrap;

    modport master (
        output flush, in_valid, imm, pc, mode, out_ready,
        input  in_ready, out_valid, imm_ext, target, jump_up, jump_down, jump_none, wrap
    );

    modport slave (
        input  flush, in_valid, imm, pc, mode, out_ready,
        output in_ready, out_valid, imm_ext, target, jump_up, jump_down, jump_none, wrap
    );
endinterface

// File: rtl/imm_branch_gen.sv
// Immediate extension and branch-target unit with a 2-entry valid/ready skid buffer.
// Results are computed at accept time and carried with each buffered entry.
module imm_branch_gen #(
    parameter int DATA_W  = 24,
    parameter int IMM_W   = 16,
    parameter int PC_STEP = 3,
    parameter int SHIFT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_branch_gen_if.slave  bus
);

    typedef struct packed {
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] target;
        logic              jump_up;
        logic              jump_down;
        logic              jump_none;
        logic              wrap;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1'b1) << (DATA_W - 1);
    localparam entry_t            ENTRY_CLEAR = '0;

    function automatic logic [DATA_W-1:0] extend_imm(
        input logic [IMM_W-1:0] imm_v,
        input logic [1:0]       mode_v
    );
        logic [DATA_W-1:0] sx;
        logic [DATA_W-1:0] zx;
        sx = DATA_W'($signed(imm_v));
        zx = DATA_W'(imm_v);
        case (mode_v)
            2'b00:   extend_imm = sx;
            2'b01:   extend_imm = zx;
            2'b10:   extend_imm = zx << (DATA_W - IMM_W);
            2'b11:   extend_imm = sx ^ MSB_MASK;
            default: extend_imm = sx;
        endcase
    endfunction

    state_t            state_r;
    entry_t            head_r;
    entry_t            skid_r;
    logic              in_ready_r;
    logic              out_valid_r;

    entry_t            new_entry_s;
    logic [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0] off_s;
    logic [DATA_W-1:0] mag_s;
    logic [DATA_W:0]   base_s;
    logic [DATA_W:0]   sum_s;
    logic              accept_s;
    logic              pop_s;

    // Build the result entry for the operands currently on the input side.
    always_comb begin
        new_entry_s = ENTRY_CLEAR;
        ext_s       = extend_imm(bus.imm, bus.mode);
        off_s       = ext_s << SHIFT;
        base_s      = {1'b0, bus.pc} + (DATA_W + 1)'(PC_STEP);
        sum_s       = {1'b0, base_s[DATA_W-1:0]} + {1'b0, off_s};
        mag_s       = -off_s;
        new_entry_s.imm_ext = ext_s;
        new_entry_s.target  = sum_s[DATA_W-1:0];
        // A carry out of pc+PC_STEP counts as a wrap whatever the offset sign.
        if (off_s[DATA_W-1]) begin
            new_entry_s.jump_up = 1'b1;
            new_entry_s.wrap    = base_s[DATA_W] | (base_s[DATA_W-1:0] < mag_s);
        end else if (off_s == {DATA_W{1'b0}}) begin
            new_entry_s.jump_none = 1'b1;
            new_entry_s.wrap      = base_s[DATA_W] | sum_s[DATA_W];
        end else begin
            new_entry_s.jump_down = 1'b1;
            new_entry_s.wrap      = base_s[DATA_W] | sum_s[DATA_W];
        end
    end

    assign accept_s = bus.in_valid & in_ready_r;
    assign pop_s    = out_valid_r & bus.out_ready;

    // Occupancy FSM: head entry drives the outputs, skid entry holds the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            head_r      <= ENTRY_CLEAR;
            skid_r      <= ENTRY_CLEAR;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            state_r     <= EMPTY;
            head_r      <= ENTRY_CLEAR;
            skid_r      <= ENTRY_CLEAR;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        head_r      <= new_entry_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end else begin
                        head_r      <= ENTRY_CLEAR;
                        out_valid_r <= 1'b0;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        head_r <= new_entry_s;
                    end else if (accept_s) begin
                        skid_r     <= new_entry_s;
                        in_ready_r <= 1'b0;
                        state_r    <= TWO;
                    end else if (pop_s) begin
                        head_r      <= ENTRY_CLEAR;
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    // Input is ignored here even on a pop; in_ready was already low.
                    if (pop_s) begin
                        head_r     <= skid_r;
                        skid_r     <= ENTRY_CLEAR;
                        in_ready_r <= 1'b1;
                        state_r    <= ONE;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    head_r      <= ENTRY_CLEAR;
                    skid_r      <= ENTRY_CLEAR;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.imm_ext   = head_r.imm_ext;
    assign bus.target    = head_r.target;
    assign bus.jump_up   = head_r.jump_up;
    assign bus.jump_down = head_r.jump_down;
    assign bus.jump_none = head_r.jump_none;
    assign bus.wrap      = head_r.wrap;

endmodule

// File: tb/tb_imm_branch_gen.sv
// Directed testbench for imm_branch_gen (DATA_W=24, IMM_W=16, PC_STEP=3, SHIFT=0).
module tb_imm_branch_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    imm_branch_gen_if #(.DATA_W(24), .IMM_W(16)) bus ();

    imm_branch_gen #(.DATA_W(24), .IMM_W(16), .PC_STEP(3), .SHIFT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [23:0] pc;
        logic [23:0] ext;
        logic [23:0] tgt;
        logic [3:0]  flg;   // {jump_up, jump_down, jump_none, wrap}
    } vec_t;

    task automatic drive(input logic [1:0] m, input logic [15:0] i, input logic [23:0] p);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.imm      = i;
        bus.pc       = p;
    endtask

    task automatic test_reset();
        logic [51:0] got;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (got !== 52'h0) begin
            failures++;
            $display("FAIL reset_payload: got %h, expected 0", got);
        end
    endtask

    task automatic test_vectors();
        vec_t        vecs [12];
        logic [51:0] got;
        logic [51:0] exp;
        vecs[0]  = {2'b00, 16'h0005, 24'h000100, 24'h000005, 24'h000108, 4'b0100};
        vecs[1]  = {2'b00, 16'hFFF0, 24'h000100, 24'hFFFFF0, 24'h0000F3, 4'b1000};
        vecs[2]  = {2'b00, 16'h0000, 24'h000040, 24'h000000, 24'h000043, 4'b0010};
        vecs[3]  = {2'b00, 16'h0002, 24'hFFFFFE, 24'h000002, 24'h000003, 4'b0101};
        vecs[4]  = {2'b01, 16'hFFF0, 24'h000000, 24'h00FFF0, 24'h00FFF3, 4'b0100};
        vecs[5]  = {2'b10, 16'h0012, 24'h000000, 24'h001200, 24'h001203, 4'b0100};
        vecs[6]  = {2'b11, 16'h0000, 24'h000000, 24'h800000, 24'h800003, 4'b1001};
        vecs[7]  = {2'b00, 16'hFFF0, 24'h000005, 24'hFFFFF0, 24'hFFFFF8, 4'b1001};
        vecs[8]  = {2'b00, 16'h7FFF, 24'hFFF000, 24'h007FFF, 24'h007002, 4'b0101};
        vecs[9]  = {2'b11, 16'h8000, 24'h000000, 24'h7F8000, 24'h7F8003, 4'b0100};
        vecs[10] = {2'b00, 16'hFFFE, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFF, 4'b1001};
        vecs[11] = {2'b10, 16'h8000, 24'h800000, 24'h800000, 24'h000003, 4'b1000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].imm, vecs[i].pc);
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_valid: out_valid=%b, expected 1", i, bus.out_valid);
            end
            got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
            exp = {vecs[i].ext, vecs[i].tgt, vecs[i].flg};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL vec%0d_result: got %h, expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b0 || got[3:0] !== 4'b0000) begin
            failures++;
            $display("FAIL drained_flags: out_valid=%b flags=%b, expected 0 0000", bus.out_valid, got[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [51:0] got;
        localparam logic [51:0] EXP_A = {24'h000001, 24'h000014, 4'b0100};
        localparam logic [51:0] EXP_B = {24'h008000, 24'h008023, 4'b0100};
        localparam logic [51:0] EXP_C = {24'hFFFFFF, 24'h000032, 4'b1000};
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(2'b00, 16'h0001, 24'h000010);
        @(negedge clk);
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || got !== EXP_A) begin
            failures++;
            $display("FAIL b2b_first: v=%b r=%b got %h, expected 1 1 %h", bus.out_valid, bus.in_ready, got, EXP_A);
        end
        drive(2'b01, 16'h8000, 24'h000020);
        @(negedge clk);
        drive(2'b00, 16'hFFFF, 24'h000030);
        for (int i = 0; i < 4; i++) begin
            got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== EXP_A) begin
                failures++;
                $display("FAIL b2b_stall%0d: v=%b r=%b got %h, expected 1 0 %h", i, bus.out_valid, bus.in_ready, got, EXP_A);
            end
            if (i < 3) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || got !== EXP_B) begin
            failures++;
            $display("FAIL b2b_second: v=%b r=%b got %h, expected 1 1 %h", bus.out_valid, bus.in_ready, got, EXP_B);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b1 || got !== EXP_C) begin
            failures++;
            $display("FAIL b2b_third: v=%b got %h, expected 1 %h", bus.out_valid, got, EXP_C);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty: v=%b r=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_flush();
        logic [51:0] got;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(2'b00, 16'h0005, 24'h000100);
        @(negedge clk);
        drive(2'b00, 16'h0006, 24'h000100);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: r=%b v=%b, expected 0 1", bus.in_ready, bus.out_valid);
        end
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(2'b00, 16'h0007, 24'h000100);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== 52'h0) begin
            failures++;
            $display("FAIL flush_clear: v=%b r=%b got %h, expected 0 1 0", bus.out_valid, bus.in_ready, got);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped: out_valid=%b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [51:0] got;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(2'b00, 16'h0005, 24'h000100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: out_valid=%b, expected 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.imm_ext, bus.target, bus.jump_up, bus.jump_down, bus.jump_none, bus.wrap};
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== 52'h0) begin
            failures++;
            $display("FAIL areset_now: v=%b r=%b got %h, expected 0 1 0", bus.out_valid, bus.in_ready, got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_after: v=%b r=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.imm       = 16'h0000;
        bus.pc        = 24'h000000;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
